instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Write-side companion to the CPU's instruction memory: accepts a byte stream over a valid/ready
//  handshake, assembles 32-bit instruction words and issues one-cycle word writes into the memory's
//  write port, replacing the file preload at bring-up. Holds the CPU stalled until the program is
//  fully loaded. Sits between the host/UART byte source and the instruction memory.
// PARAMETERS
//  DEPTH       65     instruction memory size in words; maximum loadable word count
//  BASE_ADDR   0      byte address of the first written word (multiple of 4)
//  BIG_ENDIAN  1      1: first byte of a word -> bits [31:24]; 0: first byte -> bits [7:0]
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   asynchronous reset, active-low
//  start_i         in   1   1-cycle pulse: begin a load (honoured only in IDLE, DONE, ERR)
//  byte_valid_i    in   1   source has a byte on byte_i
//  byte_i          in   8   stream byte
//  byte_ready_o    out  1   loader can accept a byte this cycle
//  wr_en_o         out  1   1-cycle memory write strobe
//  wr_addr_o       out  32  byte address of write (word aligned; memory indexes addr/4)
//  wr_data_o       out  32  assembled instruction word
//  busy_o          out  1   load in progress (HDR_HI..WRITE)
//  done_o          out  1   level: last load completed successfully
//  err_o           out  1   level: last load rejected (word count > DEPTH)
//  cpu_hold_o      out  1   stall/reset request to CPU; 0 only in DONE
// BEHAVIOUR
//  - Byte accepted on rising clk_i when byte_valid_i & byte_ready_o; byte_ready_o is registered-state
//    decoded, never depends combinationally on byte_valid_i.
//  - Stream format: 2-byte header word count N (high byte first), then 4*N data bytes.
//  - States: IDLE -start_i-> HDR_HI -byte-> HDR_LO -byte-> {N==0: DONE | N>DEPTH: ERR | else DATA}.
//    DATA: collect bytes, byte counter 0..3; 4th byte -> WRITE. WRITE (1 cycle, byte_ready_o=0):
//    wr_en_o=1, wr_addr_o=BASE_ADDR+4*word_idx, wr_data_o=assembled word; then word_idx==N-1 -> DONE,
//    else word_idx+1 -> DATA. DONE/ERR: idle, byte_ready_o=0, wait for start_i.
//  - byte_ready_o=1 only in HDR_HI, HDR_LO, DATA. Bytes offered in other states are not consumed.
//  - Latency: write strobe exactly 1 cycle after the 4th byte of a word is accepted. Peak rate
//    4 bytes per 5 cycles.
//  - Width rules: N is 16 bits, compared unsigned to DEPTH; word_idx 16 bits; wr_addr_o computed as
//    BASE_ADDR + {word_idx,2'b00} in 32 bits, no wrap possible since N<=DEPTH.
//  - start_i in busy states ignored. start_i in DONE/ERR clears done_o/err_o, sets cpu_hold_o=1,
//    zeroes counters, enters HDR_HI next cycle.
//  - Source stall mid-word: byte counter and partial word held indefinitely; no timeout.
//  - Reset (any time, incl. mid-load): state IDLE; byte_ready_o=0, wr_en_o=0, wr_addr_o=0,
//    wr_data_o=0, busy_o=0, done_o=0, err_o=0, cpu_hold_o=1. Words already written stay in memory;
//    a fresh start_i is required.
//  - wr_addr_o/wr_data_o hold their last values outside WRITE; only wr_en_o qualifies them.
// STRUCTURE
//  - Shared CPU package: state encoding constants (IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR),
//    instruction word width 32, byte width 8.
//  - One sub-module: loader_word_packer (byte counter + shift/assemble register, BIG_ENDIAN aware,
//    emits word_ready pulse). FSM, header capture and address counter stay in the top.
// TESTING
//  1 Reset released, no start: cpu_hold_o=1, byte_ready_o=0, wr_en_o never asserts for 100 cycles.
//  2 start, bytes 00 02 | 20 01 00 05 | 8C 02 00 04 (valid every cycle, BASE 0, BE): writes
//    (addr 0x0, 0x20010005) then (0x4, 0x8C020004); done_o=1, cpu_hold_o=0 one cycle after 2nd write.
//  3 Same stream with BIG_ENDIAN=0: first write data 0x05000120.
//  4 Header 00 42 (N=66 > 65): err_o=1, no wr_en_o, byte_ready_o=0 afterwards, cpu_hold_o=1.
//  5 N=1, valid toggled randomly and held low 20 cycles after 2nd data byte: single write with
//    correct word; byte_ready_o low exactly in the WRITE cycle.
//  6 rst_i low after 3 data bytes of word 1 of N=2, then new start with N=1: all outputs at reset
//    values during reset; next load writes addr 0x0 with new word only; done_o=1.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared CPU-side definitions for the instruction memory loader.
// Holds the loader state encoding and the instruction/byte widths.
package instr_mem_loader_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned HDR_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  function automatic logic takes_bytes(state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA);
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Collects four stream bytes into one instruction word and pulses word_ready
// in the cycle after the fourth byte; the output word holds until the next one.
module loader_word_packer
  import instr_mem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [BYTE_W-1:0]  data_byte,
  output logic               last_byte,
  output logic               word_ready,
  output logic [INSTR_W-1:0] word
);

  logic [1:0]                 cnt;
  logic [INSTR_W-BYTE_W-1:0]  partial;
  logic [INSTR_W-1:0]         full;

  assign last_byte = (cnt == 2'd3);

  always_comb begin
    full = BIG_ENDIAN ? {partial, data_byte} : {data_byte, partial};
  end

  // partial keeps stale bytes after a word completes; the next three bytes
  // fully overwrite it before it is ever used again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      partial    <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= byte_en && last_byte;
      if (clear) begin
        cnt     <= '0;
        partial <= '0;
      end else if (byte_en) begin
        cnt <= cnt + 2'd1;
        if (last_byte) word <= full;
        partial <= BIG_ENDIAN ? {partial[INSTR_W-2*BYTE_W-1:0], data_byte}
                              : {data_byte, partial[INSTR_W-BYTE_W-1:BYTE_W]};
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed byte program into the instruction memory write port
// and holds the CPU stalled until the whole program has been written.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned  DEPTH      = 65,
  parameter logic [31:0]  BASE_ADDR  = '0,
  parameter bit           BIG_ENDIAN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               byte_valid_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic               byte_ready_o,
  output logic               wr_en_o,
  output logic [31:0]        wr_addr_o,
  output logic [INSTR_W-1:0] wr_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               cpu_hold_o
);

  state_t             state, state_d;
  logic [BYTE_W-1:0]  hdr_hi;
  logic [HDR_W-1:0]   hdr_n;
  logic [HDR_W-1:0]   n_words;
  logic [HDR_W-1:0]   word_idx;
  logic               accept;
  logic               start_ok;
  logic               last_byte;

  assign accept   = byte_valid_i & byte_ready_o;
  assign start_ok = start_i & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign hdr_n    = {hdr_hi, byte_i};

  loader_word_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .clear      (start_ok),
    .byte_en    (accept && (state == DATA)),
    .data_byte  (byte_i),
    .last_byte  (last_byte),
    .word_ready (wr_en_o),
    .word       (wr_data_o)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE, ERR: if (start_ok) state_d = HDR_HI;
      HDR_HI:          if (accept) state_d = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_n == '0)                    state_d = DONE;
          else if ({16'd0, hdr_n} > DEPTH)    state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA:            if (accept && last_byte) state_d = WRITE;
      WRITE:           state_d = (word_idx + 16'd1 == n_words) ? DONE : DATA;
      default:         state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      hdr_hi       <= '0;
      n_words      <= '0;
      word_idx     <= '0;
      wr_addr_o    <= '0;
      byte_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      cpu_hold_o   <= 1'b1;
    end else begin
      state        <= state_d;
      byte_ready_o <= takes_bytes(state_d);
      busy_o       <= takes_bytes(state_d) || (state_d == WRITE);
      done_o       <= (state_d == DONE);
      err_o        <= (state_d == ERR);
      cpu_hold_o   <= (state_d != DONE);
      if (start_ok) begin
        n_words  <= '0;
        word_idx <= '0;
      end
      unique case (state)
        HDR_HI: if (accept) hdr_hi <= byte_i;
        HDR_LO: if (accept) n_words <= hdr_n;
        DATA:   if (accept && last_byte)
                  wr_addr_o <= BASE_ADDR + {14'd0, word_idx, 2'b00};
        WRITE:  if (state_d == DATA) word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a big-endian (base 0) and a little-endian (base 0x100)
// instance share one stimulus stream and are checked every cycle against a stream model.
module tb_instr_mem_loader;

  localparam int          DEPTH   = 65;
  localparam logic [31:0] BASE_LE = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  bdat = 8'h00;

  logic        rdy_be, wen_be, busy_be, done_be, err_be, hold_be;
  logic [31:0] addr_be, data_be;
  logic        rdy_le, wen_le, busy_le, done_le, err_le, hold_le;
  logic [31:0] addr_le, data_le;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .BIG_ENDIAN(1'b1)) dut_be (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .byte_valid_i(valid), .byte_i(bdat),
    .byte_ready_o(rdy_be), .wr_en_o(wen_be), .wr_addr_o(addr_be), .wr_data_o(data_be),
    .busy_o(busy_be), .done_o(done_be), .err_o(err_be), .cpu_hold_o(hold_be));

  instr_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_LE), .BIG_ENDIAN(1'b0)) dut_le (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .byte_valid_i(valid), .byte_i(bdat),
    .byte_ready_o(rdy_le), .wr_en_o(wen_le), .wr_addr_o(addr_le), .wr_data_o(data_le),
    .busy_o(busy_le), .done_o(done_le), .err_o(err_le), .cpu_hold_o(hold_le));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Stream model: progress is tracked as a count of consumed bytes
  bit          m_loading, m_done, m_err, m_hold, m_wen;
  int          m_consumed, m_n, m_written;
  logic [7:0]  m_hi;
  logic [7:0]  m_cur [4];
  logic [31:0] m_addr_be, m_addr_le, m_data_be, m_data_le;

  always @(posedge clk or negedge rst_n) begin
    bit was_loading, was_wen, cur_ready;
    int k;
    if (!rst_n) begin
      m_loading = 0; m_done = 0; m_err = 0; m_hold = 1; m_wen = 0;
      m_consumed = 0; m_n = 0; m_written = 0; m_hi = 8'h00;
      m_addr_be = '0; m_addr_le = '0; m_data_be = '0; m_data_le = '0;
    end else begin
      was_loading = m_loading;
      was_wen     = m_wen;
      cur_ready   = m_loading && !m_wen;
      m_wen       = 0;
      if (was_wen) begin
        m_written++;
        if (m_written == m_n) begin
          m_loading = 0; m_done = 1; m_hold = 0;
        end
      end
      if (!was_loading && start) begin
        m_loading = 1; m_done = 0; m_err = 0; m_hold = 1;
        m_consumed = 0; m_n = 0; m_written = 0;
      end else if (cur_ready && valid) begin
        m_consumed++;
        if (m_consumed == 1) m_hi = bdat;
        else if (m_consumed == 2) begin
          m_n = int'({m_hi, bdat});
          if (m_n == 0) begin
            m_loading = 0; m_done = 1; m_hold = 0;
          end else if (m_n > DEPTH) begin
            m_loading = 0; m_err = 1;
          end
        end else begin
          k = m_consumed - 3;
          m_cur[k % 4] = bdat;
          if (k % 4 == 3) begin
            m_wen     = 1;
            m_addr_be = 32'(4 * (k / 4));
            m_addr_le = BASE_LE + 32'(4 * (k / 4));
            m_data_be = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
            m_data_le = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
          end
        end
      end
    end
  end

  logic [63:0] q_be[$];
  logic [63:0] q_le[$];

  always @(negedge clk) begin
    chk("be.ready", 32'(rdy_be),  32'(m_loading && !m_wen));
    chk("be.wr_en", 32'(wen_be),  32'(m_wen));
    chk("be.addr",  addr_be,      m_addr_be);
    chk("be.data",  data_be,      m_data_be);
    chk("be.busy",  32'(busy_be), 32'(m_loading));
    chk("be.done",  32'(done_be), 32'(m_done));
    chk("be.err",   32'(err_be),  32'(m_err));
    chk("be.hold",  32'(hold_be), 32'(m_hold));
    chk("le.ready", 32'(rdy_le),  32'(m_loading && !m_wen));
    chk("le.wr_en", 32'(wen_le),  32'(m_wen));
    chk("le.addr",  addr_le,      m_addr_le);
    chk("le.data",  data_le,      m_data_le);
    chk("le.busy",  32'(busy_le), 32'(m_loading));
    chk("le.done",  32'(done_le), 32'(m_done));
    chk("le.err",   32'(err_le),  32'(m_err));
    chk("le.hold",  32'(hold_le), 32'(m_hold));
    if (wen_be) q_be.push_back({addr_be, data_be});
    if (wen_le) q_le.push_back({addr_le, data_le});
  end

  // All driver tasks start and end at 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    int guard;
    guard = 0;
    acc   = 0;
    while (!acc && guard < 100) begin
      bdat  = b;
      valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = valid && rdy_be;
      @(posedge clk); #1;
      guard++;
    end
    valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: byte %h not accepted, required within 100 cycles", b);
    end
  endtask

  task automatic send_list(input logic [7:0] bl[$], input bit rnd);
    foreach (bl[i]) send_byte(bl[i], rnd);
  endtask

  task automatic wait_end();
    int guard;
    guard = 0;
    while (!(done_be || err_be) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      tests++; fails++;
      $display("FAIL end_timeout: done/err still 0, required within 200 cycles");
    end
  endtask

  initial begin
    logic [7:0] bl[$];

    idle(3);
    rst_n = 1'b1;

    // Reset released, no start
    idle(100);
    chk("t1.writes", 32'(q_be.size()), 32'd0);
    chk("t1.hold",   32'(hold_be),     32'd1);
    chk("t1.ready",  32'(rdy_be),      32'd0);

    // Two-word program, valid every cycle
    q_be.delete(); q_le.delete();
    pulse_start();
    bl = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
    send_list(bl, 1'b0);
    wait_end();
    chk("t2.writes",  32'(q_be.size()), 32'd2);
    if (q_be.size() == 2 && q_le.size() == 2) begin
      chk("t2.addr0",   q_be[0][63:32], 32'h0);
      chk("t2.data0",   q_be[0][31:0],  32'h20010005);
      chk("t2.addr1",   q_be[1][63:32], 32'h4);
      chk("t2.data1",   q_be[1][31:0],  32'h8C020004);
      chk("t3.le_addr", q_le[0][63:32], 32'h100);
      chk("t3.le_data", q_le[0][31:0],  32'h05000120);
    end
    chk("t2.done", 32'(done_be), 32'd1);
    chk("t2.hold", 32'(hold_be), 32'd0);

    // Empty program
    q_be.delete(); q_le.delete();
    pulse_start();
    bl = '{8'h00, 8'h00};
    send_list(bl, 1'b0);
    wait_end();
    chk("n0.writes", 32'(q_be.size()), 32'd0);
    chk("n0.done",   32'(done_be),     32'd1);

    // Oversized program rejected; further bytes are not consumed
    pulse_start();
    bl = '{8'h00, 8'h42};
    send_list(bl, 1'b0);
    wait_end();
    chk("t4.err",  32'(err_be),  32'd1);
    chk("t4.hold", 32'(hold_be), 32'd1);
    bdat = 8'h55; valid = 1'b1;
    idle(5);
    valid = 1'b0;
    chk("t4.writes", 32'(q_be.size()), 32'd0);
    chk("t4.ready",  32'(rdy_be),      32'd0);

    // Single word, irregular valid, long mid-word stall with a stray start
    pulse_start();
    bl = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_list(bl, 1'b1);
    idle(10);
    pulse_start();
    idle(9);
    bl = '{8'h56, 8'h78};
    send_list(bl, 1'b1);
    wait_end();
    chk("t5.writes", 32'(q_be.size()), 32'd1);
    if (q_be.size() == 1 && q_le.size() == 1) begin
      chk("t5.data_be", q_be[0][31:0],  32'h12345678);
      chk("t5.data_le", q_le[0][31:0],  32'h78563412);
      chk("t5.addr_le", q_le[0][63:32], 32'h100);
    end

    // Reset mid-word, then a fresh one-word load
    q_be.delete(); q_le.delete();
    pulse_start();
    bl = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    send_list(bl, 1'b0);
    rst_n = 1'b0;
    idle(3);
    chk("t6.rst_data", data_be,       32'h0);
    chk("t6.rst_addr", addr_le,       32'h0);
    chk("t6.rst_hold", 32'(hold_be),  32'd1);
    rst_n = 1'b1;
    idle(2);
    pulse_start();
    bl = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_list(bl, 1'b0);
    wait_end();
    chk("t6.writes", 32'(q_be.size()), 32'd1);
    if (q_be.size() == 1) chk("t6.word", q_be[0][31:0], 32'hDEADBEEF);
    chk("t6.done", 32'(done_be), 32'd1);

    // Program of exactly DEPTH words
    q_be.delete(); q_le.delete();
    pulse_start();
    bl = '{8'h00, 8'h41};
    for (int i = 0; i < 4 * DEPTH; i++) bl.push_back(8'(i));
    send_list(bl, 1'b0);
    wait_end();
    chk("max.writes", 32'(q_be.size()), 32'd65);
    if (q_be.size() == 65) begin
      chk("max.last_addr", q_be[64][63:32], 32'h100);
      chk("max.last_data", q_be[64][31:0],  32'h00010203);
    end
    chk("max.done", 32'(done_be), 32'd1);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
